// File: rtl/mull_unit.sv
// rtl/mull_unit.sv - iterative shift-add multiplier for MULL in the execute stage
//
// Captures operands when a MULL reaches E and stalls the pipeline until the
// 2*WIDTH-bit product is in Hi:Lo. Signed multiplies run on magnitudes and
// negate the result at the end.
//
// Optional build macro: MULL_RADIX4_EN (retire two multiplier bits per cycle).
//
// Ports:
//   Clock   in   rising-edge clock
//   nReset  in   asynchronous active-low reset
//   Start   in   MULL present in E (held while it stays there)
//   Signed  in   1 = signed, 0 = unsigned; sampled with Start
//   Flush   in   abort any in-flight multiply
//   A, B    in   operands, sampled on the accepting edge
//   nStall  out  0 = hold the pipeline (combinational)
//   Done    out  one-cycle pulse when Hi/Lo become valid
//   Hi, Lo  out  upper / lower halves of the product

module mull_unit #(
    parameter int WIDTH = 32
) (
    input  logic             Clock,
    input  logic             nReset,
    input  logic             Start,
    input  logic             Signed,
    input  logic             Flush,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             nStall,
    output logic             Done,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

`ifdef MULL_RADIX4_EN
    localparam int N_ITER = WIDTH / 2;
`else
    localparam int N_ITER = WIDTH;
`endif
    localparam int CW = $clog2(N_ITER + 1);
    localparam logic [CW-1:0]        C_LOAD = CW'(N_ITER);
    localparam logic [CW-1:0]        C_ONE  = CW'(1);
    localparam logic [WIDTH-1:0]     W_ONE  = WIDTH'(1);
    localparam logic [2*WIDTH-1:0]   P_ONE  = (2*WIDTH)'(1);

    logic [1:0]         r_state;
    logic [CW-1:0]      r_cnt;
    // Upper half accumulates partial products; lower half starts as the
    // multiplier and is shifted out one (or two) bits per iteration.
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_mcand;
    logic               r_neg;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;

    logic               w_accept;
    logic               w_last;
    logic               w_neg;
    logic [WIDTH-1:0]   w_abs_a;
    logic [WIDTH-1:0]   w_abs_b;
    logic [2*WIDTH-1:0] w_acc_next;
    logic [2*WIDTH-1:0] w_prod;

    assign w_accept = (r_state == S_IDLE) && Start && !Flush;
    assign w_last   = (r_cnt == C_ONE);
    assign w_neg    = Signed & (A[WIDTH-1] ^ B[WIDTH-1]);

    // Unsigned WIDTH-bit magnitudes: the most negative value maps onto
    // 2^(WIDTH-1) without overflow.
    assign w_abs_a = (Signed && A[WIDTH-1]) ? (~A + W_ONE) : A;
    assign w_abs_b = (Signed && B[WIDTH-1]) ? (~B + W_ONE) : B;

`ifdef MULL_RADIX4_EN
    // 3x multiplicand is precomputed at accept so the iteration adder sees
    // only a 4-way select.
    logic [WIDTH+1:0] r_mcand3;
    logic [WIDTH+1:0] w_addend;
    logic [WIDTH+1:0] w_sum;

    always_comb begin
        w_addend = '0;
        case (r_acc[1:0])
            2'd0:    w_addend = '0;
            2'd1:    w_addend = {2'b00, r_mcand};
            2'd2:    w_addend = {1'b0, r_mcand, 1'b0};
            default: w_addend = r_mcand3;
        endcase
    end

    // hi < 2^W and addend < 3*2^W, so the sum fits in W+2 bits.
    assign w_sum      = {2'b00, r_acc[2*WIDTH-1:WIDTH]} + w_addend;
    assign w_acc_next = {w_sum, r_acc[WIDTH-1:2]};
`else
    logic [WIDTH:0] w_sum;

    assign w_sum      = {1'b0, r_acc[2*WIDTH-1:WIDTH]}
                      + (r_acc[0] ? {1'b0, r_mcand} : {(WIDTH+1){1'b0}});
    assign w_acc_next = {w_sum, r_acc[WIDTH-1:1]};
`endif

    assign w_prod = r_neg ? (~w_acc_next + P_ONE) : w_acc_next;

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_neg    <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
`ifdef MULL_RADIX4_EN
            r_mcand3 <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_acc   <= {{WIDTH{1'b0}}, w_abs_b};
                        r_mcand <= w_abs_a;
                        r_neg   <= w_neg;
                        r_cnt   <= C_LOAD;
`ifdef MULL_RADIX4_EN
                        r_mcand3 <= {2'b00, w_abs_a} + {1'b0, w_abs_a, 1'b0};
`endif
                        r_state <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (Flush) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_acc <= w_acc_next;
                        r_cnt <= r_cnt - C_ONE;
                        if (w_last) begin
                            r_hi    <= w_prod[2*WIDTH-1:WIDTH];
                            r_lo    <= w_prod[WIDTH-1:0];
                            r_state <= S_DONE;
                        end
                    end
                end
                // Start is still high here for the instruction just
                // finished, so it must not be taken as a new MULL.
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Gated by nReset so the pipeline is released while reset is held,
    // even with Start high.
    assign nStall = !nReset || !(w_accept || (r_state == S_BUSY));
    assign Done   = (r_state == S_DONE);
    assign Hi     = r_hi;
    assign Lo     = r_lo;

endmodule
